// File: rtl/wall_pkg.sv
// wall_pkg -- shared types and constants for the scrolling wall field.
//   wall_state_e  : control FSM states
//   wall_slot_t   : one wall slot (active flag, left edge x, gap top gap_y)
//   SCREEN_H_MAX  : visible screen height in pixels
//   gap_from_rand : maps a random word onto a gap top that keeps the gap on screen
package wall_pkg;

  localparam int SCREEN_H_MAX = 480;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SPAWN_REQ,
    SPAWN_LOAD
  } wall_state_e;

  typedef struct packed {
    logic        active;
    logic [10:0] x;
    logic [10:0] gap_y;
  } wall_slot_t;

  // Values that would push the gap past the bottom edge are folded back up by 256.
  function automatic logic [10:0] gap_from_rand(input logic [10:0] rand_word,
                                                input int          gap_h);
    logic [8:0] r;
    r = rand_word[8:0];
    if (int'(r) <= SCREEN_H_MAX - gap_h) return {2'b00, r};
    else return {2'b00, r - 9'd256};
  endfunction

endpackage

// File: rtl/wall_hit.sv
// wall_hit -- registered pixel-hit test for one wall slot.
//   pixel_clk, reset : clock, asynchronous active-high reset
//   slot             : slot record under test
//   hcount, vcount   : current scan coordinates
//   hit              : one cycle later, the pixel lies on this wall's solid part
module wall_hit
  import wall_pkg::*;
#(
  parameter int WALL_W = 32,
  parameter int GAP_H  = 120
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  wall_slot_t  slot,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        hit
);

  // 12-bit arithmetic so x + WALL_W near the right edge never wraps.
  logic [11:0] h, v, x_lo, x_hi, g_lo, g_hi;
  logic        in_x, in_gap;

  assign h      = {1'b0, hcount};
  assign v      = {1'b0, vcount};
  assign x_lo   = {1'b0, slot.x};
  assign x_hi   = {1'b0, slot.x} + 12'(WALL_W);
  assign g_lo   = {1'b0, slot.gap_y};
  assign g_hi   = {1'b0, slot.gap_y} + 12'(GAP_H);
  assign in_x   = (h >= x_lo) && (h < x_hi);
  assign in_gap = (v >= g_lo) && (v < g_hi);

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) hit <= 1'b0;
    else       hit <= slot.active && in_x && !in_gap;
  end

endmodule

// File: rtl/wall_field.sv
// wall_field -- scrolling wall slots with periodic spawning and a pixel query.
//   pixel_clk, reset      : clock, asynchronous active-high reset
//   enable                : 1 = scroll and spawn, 0 = frozen (pixel query stays live)
//   frame_tick            : one-cycle pulse per frame at vblank start
//   rand_y/rand_valid     : random word from the upstream source, valid strobe
//   rand_req              : asking for a random word (handshake with rand_valid)
//   hcount, vcount        : scan coordinates; wall_pixel answers one cycle later
//   wall_count            : number of active slots
//   busy                  : control FSM is not in IDLE
// Optional feature: define WALL_SPEEDUP_EN to raise the scroll speed by one after
// every 8 spawns, saturating at 2*SPEED. Without it the speed is fixed at SPEED.
module wall_field
  import wall_pkg::*;
#(
  parameter int NUM_WALLS    = 4,
  parameter int WALL_W       = 32,
  parameter int GAP_H        = 120,
  parameter int SCREEN_W     = 640,
  parameter int SPAWN_FRAMES = 90,
  parameter int SPEED        = 2
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [10:0] rand_y,
  input  logic        rand_valid,
  output logic        rand_req,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        wall_pixel,
  output logic [2:0]  wall_count,
  output logic        busy
);

  localparam int               IDX_W    = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WALLS - 1);
  localparam logic [15:0]      DUE_CNT  = 16'(SPAWN_FRAMES - 1);

  wall_state_e          state, state_next;
  wall_slot_t           slots [NUM_WALLS];
  wall_slot_t           moved_slot;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     free_idx;
  logic                 free_found;
  logic [NUM_WALLS-1:0] active_now, active_after, hits;
  logic                 free_after;
  logic [15:0]          spawn_cnt;
  logic                 spawn_due;
  logic                 pending;
  logic [10:0]          rand_hold;
  logic [10:0]          speed;
  logic [2:0]           active_total;

  // ---------------------------------------------------------------------------
  // Slot bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    active_total = '0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      active_now[i] = slots[i].active;
      active_total  = active_total + 3'(slots[i].active);
    end
  end

  // Result of scrolling the slot currently addressed in MOVE.
  always_comb begin
    moved_slot = slots[idx];
    if (moved_slot.active) begin
      if (moved_slot.x < speed) moved_slot.active = 1'b0;
      else                      moved_slot.x      = moved_slot.x - speed;
    end
  end

  // The spawn decision on the last MOVE cycle must see that cycle's own update.
  always_comb begin
    active_after = active_now;
    if (state == MOVE) active_after[idx] = moved_slot.active;
    free_after = ~&active_after;
  end

  // Lowest-index free slot: scan downward so the smallest index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_WALLS - 1; i >= 0; i--) begin
      if (!slots[i].active) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn_due = (spawn_cnt == DUE_CNT);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rand_req   = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable && (frame_tick || pending)) state_next = MOVE;
      end
      MOVE: begin
        if (idx == LAST_IDX) state_next = (spawn_due && free_after) ? SPAWN_REQ : IDLE;
      end
      SPAWN_REQ: begin
        rand_req = 1'b1;
        if (rand_valid) state_next = SPAWN_LOAD;
      end
      SPAWN_LOAD: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      // NOTE: the slot array is a handful of flops, not a RAM, so it is cleared
      // here like any other state; a real memory would not be reset this way.
      for (int i = 0; i < NUM_WALLS; i++) slots[i] <= '0;
      idx        <= '0;
      spawn_cnt  <= '0;
      pending    <= 1'b0;
      rand_hold  <= '0;
      wall_count <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees
      // the pre-edge values of the others regardless of statement order.
      wall_count <= active_total;

      // A tick that lands while busy is remembered once; extra ticks are dropped.
      if (state == IDLE) begin
        if (state_next == MOVE) pending <= 1'b0;
      end else if (enable && frame_tick) begin
        pending <= 1'b1;
      end

      unique case (state)
        IDLE: idx <= '0;
        MOVE: begin
          slots[idx] <= moved_slot;
          idx        <= idx + IDX_W'(1);
          if (idx == LAST_IDX) spawn_cnt <= spawn_due ? 16'd0 : spawn_cnt + 16'd1;
        end
        SPAWN_REQ: if (rand_valid) rand_hold <= rand_y;
        SPAWN_LOAD: begin
          if (free_found) begin
            slots[free_idx] <= '{active: 1'b1,
                                 x:      11'(SCREEN_W),
                                 gap_y:  gap_from_rand(rand_hold, GAP_H)};
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scroll speed
  // ---------------------------------------------------------------------------
`ifdef WALL_SPEEDUP_EN
  logic [2:0] spawn_tally;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      speed       <= 11'(SPEED);
      spawn_tally <= '0;
    end else if (state == SPAWN_LOAD && free_found) begin
      spawn_tally <= spawn_tally + 3'd1;
      // The eighth spawn wraps the tally and bumps the speed.
      if (spawn_tally == 3'd7 && speed < 11'(2 * SPEED)) speed <= speed + 11'd1;
    end
  end
`else
  assign speed = 11'(SPEED);
`endif

  // ---------------------------------------------------------------------------
  // Pixel query
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_WALLS; g++) begin : g_hit
    wall_hit #(
      .WALL_W(WALL_W),
      .GAP_H (GAP_H)
    ) u_hit (
      .pixel_clk(pixel_clk),
      .reset    (reset),
      .slot     (slots[g]),
      .hcount   (hcount),
      .vcount   (vcount),
      .hit      (hits[g])
    );
  end

  assign wall_pixel = |hits;

endmodule

// File: tb/tb_wall_field.sv
// tb_wall_field -- directed bench for wall_field.
// Main instance uses default parameters; a small instance (2 slots, spawn at
// x=5 every 4 frames) reaches the x=1 / speed 2 expiry case in a few frames.
module tb_wall_field;

  logic        pixel_clk = 1'b0;
  logic        reset, enable, frame_tick, rand_valid;
  logic [10:0] rand_y, hcount, vcount;
  logic        rand_req, wall_pixel, busy;
  logic [2:0]  wall_count;

  logic        frame_tick2;
  logic [10:0] hcount2, vcount2;
  logic        rand_req2, wall_pixel2, busy2;
  logic [2:0]  wall_count2;

  int total = 0;
  int bad   = 0;

  always #5 pixel_clk = ~pixel_clk;

  wall_field dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .enable    (enable),
    .frame_tick(frame_tick),
    .rand_y    (rand_y),
    .rand_valid(rand_valid),
    .rand_req  (rand_req),
    .hcount    (hcount),
    .vcount    (vcount),
    .wall_pixel(wall_pixel),
    .wall_count(wall_count),
    .busy      (busy)
  );

  wall_field #(
    .NUM_WALLS   (2),
    .SCREEN_W    (5),
    .SPAWN_FRAMES(4)
  ) dut_small (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .enable    (enable),
    .frame_tick(frame_tick2),
    .rand_y    (11'd100),
    .rand_valid(1'b1),
    .rand_req  (rand_req2),
    .hcount    (hcount2),
    .vcount    (vcount2),
    .wall_pixel(wall_pixel2),
    .wall_count(wall_count2),
    .busy      (busy2)
  );

  // ---------------------------------------------------------------- helpers
  task automatic run_frame();
    int n = 0;
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    while (busy === 1'b1 && n < 64) begin
      @(negedge pixel_clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL frame_timeout: busy=%b required 0", busy);
    end
    @(negedge pixel_clk);
  endtask

  task automatic run_frame_small();
    int n = 0;
    @(negedge pixel_clk) frame_tick2 = 1'b1;
    @(negedge pixel_clk) frame_tick2 = 1'b0;
    while (busy2 === 1'b1 && n < 64) begin
      @(negedge pixel_clk);
      n++;
    end
    if (busy2 !== 1'b0) begin
      total++; bad++;
      $display("FAIL small_frame_timeout: busy=%b required 0", busy2);
    end
    @(negedge pixel_clk);
  endtask

  task automatic probe(input int h, input int v, output logic pix);
    @(negedge pixel_clk);
    hcount = 11'(h);
    vcount = 11'(v);
    @(negedge pixel_clk);
    pix = wall_pixel;
  endtask

  task automatic probe_small(input int h, input int v, output logic pix);
    @(negedge pixel_clk);
    hcount2 = 11'(h);
    vcount2 = 11'(v);
    @(negedge pixel_clk);
    pix = wall_pixel2;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    repeat (3) @(negedge pixel_clk);
    total++; if (wall_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", wall_count); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (rand_req !== 1'b0)   begin bad++; $display("FAIL reset_req: got %b required 0", rand_req); end
    total++; if (wall_pixel !== 1'b0) begin bad++; $display("FAIL reset_pixel: got %b required 0", wall_pixel); end
    total++; if (wall_count2 !== 3'd0) begin bad++; $display("FAIL reset_count_small: got %0d required 0", wall_count2); end
    reset = 1'b0;
    repeat (2) @(negedge pixel_clk);
  endtask

  task automatic test_first_spawn();
    int   ph[4] = '{640, 639, 640, 640};
    int   pv[4] = '{50, 50, 99, 100};
    bit   pe[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic pix;
    rand_y = 11'd100;
    rand_valid = 1'b1;
    repeat (89) run_frame();
    total++; if (wall_count !== 3'd0) begin bad++; $display("FAIL spawn_early: count=%0d required 0", wall_count); end
    run_frame();
    total++; if (wall_count !== 3'd1) begin bad++; $display("FAIL spawn_90: count=%0d required 1", wall_count); end
    for (int i = 0; i < 4; i++) begin
      probe(ph[i], pv[i], pix);
      total++;
      if (pix !== pe[i]) begin bad++; $display("FAIL spawn_pixel(%0d,%0d): got %b required %b", ph[i], pv[i], pix, pe[i]); end
    end
  endtask

  task automatic test_pixel();
    int   ph[5] = '{650, 650, 672, 671, 671};
    int   pv[5] = '{50, 150, 50, 219, 220};
    bit   pe[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic pix;
    for (int i = 0; i < 5; i++) begin
      probe(ph[i], pv[i], pix);
      total++;
      if (pix !== pe[i]) begin bad++; $display("FAIL pixel(%0d,%0d): got %b required %b", ph[i], pv[i], pix, pe[i]); end
    end
  endtask

  // Tick held for three edges: one starts a frame, two land while busy.
  task automatic test_back_to_back();
    int   ph[4] = '{636, 635, 667, 668};
    bit   pe[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic pix;
    @(negedge pixel_clk) frame_tick = 1'b1;
    repeat (3) @(negedge pixel_clk);
    frame_tick = 1'b0;
    repeat (20) @(negedge pixel_clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy: got %b required 0", busy); end
    for (int i = 0; i < 4; i++) begin
      probe(ph[i], 50, pix);
      total++;
      if (pix !== pe[i]) begin bad++; $display("FAIL b2b_pixel(%0d,50): got %b required %b", ph[i], pix, pe[i]); end
    end
  endtask

  task automatic test_enable();
    logic pix;
    enable = 1'b0;
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL disabled_busy: got %b required 0", busy); end
    probe(636, 50, pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL disabled_pixel_live: got %b required 1", pix); end
    enable = 1'b1;
    repeat (10) @(negedge pixel_clk);
    probe(635, 50, pix);
    total++; if (pix !== 1'b0) begin bad++; $display("FAIL disabled_not_pended: got %b required 0", pix); end
    probe(636, 50, pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL disabled_hold: got %b required 1", pix); end
  endtask

  task automatic test_gap();
    int   ph1[4] = '{645, 645, 645, 645};
    int   pv1[4] = '{254, 255, 374, 375};
    bit   pe1[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   pv3[4] = '{104, 105, 224, 225};
    bit   pe3[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic pix;
    // 0x1FF folds to 255; slot0 sits at 460 by then.
    rand_y = 11'h1FF;
    repeat (88) run_frame();
    total++; if (wall_count !== 3'd2) begin bad++; $display("FAIL gap1ff_count: got %0d required 2", wall_count); end
    for (int i = 0; i < 4; i++) begin
      probe(ph1[i], pv1[i], pix);
      total++;
      if (pix !== pe1[i]) begin bad++; $display("FAIL gap1ff(%0d,%0d): got %b required %b", ph1[i], pv1[i], pix, pe1[i]); end
    end
    // 360 is the largest value kept as-is.
    rand_y = 11'd360;
    repeat (90) run_frame();
    total++; if (wall_count !== 3'd3) begin bad++; $display("FAIL gap360_count: got %0d required 3", wall_count); end
    probe(645, 359, pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL gap360_above: got %b required 1", pix); end
    probe(645, 360, pix);
    total++; if (pix !== 1'b0) begin bad++; $display("FAIL gap360_top: got %b required 0", pix); end
    // 361 folds to 105; slots now at 100, 280, 460, 640.
    rand_y = 11'd361;
    repeat (90) run_frame();
    total++; if (wall_count !== 3'd4) begin bad++; $display("FAIL gap361_count: got %0d required 4", wall_count); end
    for (int i = 0; i < 4; i++) begin
      probe(645, pv3[i], pix);
      total++;
      if (pix !== pe3[i]) begin bad++; $display("FAIL gap361(645,%0d): got %b required %b", pv3[i], pix, pe3[i]); end
    end
    probe(100, 50, pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL slot0_x100: got %b required 1", pix); end
    probe(99, 50, pix);
    total++; if (pix !== 1'b0) begin bad++; $display("FAIL slot0_x99: got %b required 0", pix); end
    probe(290, 300, pix);
    total++; if (pix !== 1'b0) begin bad++; $display("FAIL slot1_gap: got %b required 0", pix); end
  endtask

  // Small instance: spawn x=5 on frame 4, x=3, x=1, then freed on frame 7.
  task automatic test_expire();
    logic pix;
    repeat (4) run_frame_small();
    total++; if (wall_count2 !== 3'd1) begin bad++; $display("FAIL small_spawn: count=%0d required 1", wall_count2); end
    probe_small(5, 50, pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL small_x5: got %b required 1", pix); end
    probe_small(4, 50, pix);
    total++; if (pix !== 1'b0) begin bad++; $display("FAIL small_x4: got %b required 0", pix); end
    repeat (2) run_frame_small();
    probe_small(1, 50, pix);
    total++; if (pix !== 1'b1) begin bad++; $display("FAIL small_x1: got %b required 1", pix); end
    probe_small(0, 50, pix);
    total++; if (pix !== 1'b0) begin bad++; $display("FAIL small_x0: got %b required 0", pix); end
    total++; if (wall_count2 !== 3'd1) begin bad++; $display("FAIL small_alive: count=%0d required 1", wall_count2); end
    run_frame_small();
    total++; if (wall_count2 !== 3'd0) begin bad++; $display("FAIL small_expired: count=%0d required 0", wall_count2); end
    probe_small(1, 50, pix);
    total++; if (pix !== 1'b0) begin bad++; $display("FAIL small_gone: got %b required 0", pix); end
  endtask

  // Slot0 expires on frame 51; frame 90 is due with a free slot and stalls in
  // SPAWN_REQ because rand_valid is low, then reset lands mid-cycle.
  task automatic test_reset_handshake();
    int n = 0;
    rand_valid = 1'b0;
    repeat (89) run_frame();
    total++; if (wall_count !== 3'd3) begin bad++; $display("FAIL expire_count: got %0d required 3", wall_count); end
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    while (rand_req !== 1'b1 && n < 64) begin
      @(negedge pixel_clk);
      n++;
    end
    total++; if (rand_req !== 1'b1) begin bad++; $display("FAIL req_timeout: rand_req=%b required 1", rand_req); end
    repeat (3) @(negedge pixel_clk);
    total++; if (rand_req !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL req_stall: rand_req=%b busy=%b required 1 1", rand_req, busy);
    end
    #2 reset = 1'b1;
    #1;
    total++; if (rand_req !== 1'b0)   begin bad++; $display("FAIL rst_req: got %b required 0", rand_req); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    total++; if (wall_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d required 0", wall_count); end
    @(negedge pixel_clk);
    reset = 1'b0;
    rand_valid = 1'b1;
    repeat (10) @(negedge pixel_clk);
    total++; if (wall_count !== 3'd0 || busy !== 1'b0 || rand_req !== 1'b0) begin
      bad++; $display("FAIL rst_discard: count=%0d busy=%b req=%b required 0 0 0", wall_count, busy, rand_req);
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    frame_tick  = 1'b0;
    rand_valid  = 1'b0;
    rand_y      = '0;
    hcount      = '0;
    vcount      = '0;
    frame_tick2 = 1'b0;
    hcount2     = '0;
    vcount2     = '0;

    test_reset();
    test_first_spawn();
    test_pixel();
    test_back_to_back();
    test_enable();
    test_gap();
    test_expire();
    test_reset_handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
